// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO on a wrap-bit pointer pair, any DEPTH >= 2.
// Occupancy count, almost flags, flush and optional empty bypass.
module sync_fifo_flex #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int PASSTHRU  = 0,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [WIDTH-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [WIDTH-1:0] send_msg,
  output logic [CNT_W-1:0] count,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEP_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] r_idx;
  logic             w_wrap;
  logic             r_wrap;

  logic             same;
  logic             empty;
  logic             full;
  logic             live;
  logic             bypass;
  logic             enq;
  logic             deq;
  logic             wr;
  logic             rd;
  logic [CNT_W-1:0] occ;

  assign same   = (w_idx == r_idx);
  assign empty  = same & (w_wrap == r_wrap);
  assign full   = same & (w_wrap != r_wrap);
  assign live   = ~flush & ~rst;
  assign bypass = (PASSTHRU != 0) & empty & live;

  assign recv_rdy = ~full & live;
  assign send_val = bypass ? recv_val : (~empty & live);
  assign send_msg = bypass ? recv_msg : mem[r_idx];

  assign enq = recv_val & recv_rdy;
  assign deq = send_val & send_rdy;
  // a word consumed straight through the bypass never touches storage
  assign wr  = enq & ~(bypass & send_rdy);
  assign rd  = deq & ~bypass;

  assign occ = (w_wrap == r_wrap)
             ? CNT_W'(w_idx) - CNT_W'(r_idx)
             : DEP_C + CNT_W'(w_idx) - CNT_W'(r_idx);

  assign count        = rst ? '0 : occ;
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[w_idx] <= recv_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      w_idx  <= '0;
      r_idx  <= '0;
      w_wrap <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (wr) begin
        if (w_idx == LAST) begin
          w_idx  <= '0;
          w_wrap <= ~w_wrap;
        end else begin
          w_idx <= w_idx + IDX_W'(1);
        end
      end
      if (rd) begin
        if (r_idx == LAST) begin
          r_idx  <= '0;
          r_wrap <= ~r_wrap;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: directed scenarios plus random traffic
// against a queue model; a second instance exercises bypass.
module tb_sync_fifo_flex;

  localparam int DEP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_fl = 1'b0;
  logic       a_rv = 1'b0;
  logic       a_rr;
  logic [7:0] a_rm = '0;
  logic       a_sv;
  logic       a_sr = 1'b0;
  logic [7:0] a_sm;
  logic [2:0] a_cnt;
  logic       a_af;
  logic       a_ae;

  logic       b_fl = 1'b0;
  logic       b_rv = 1'b0;
  logic       b_rr;
  logic [7:0] b_rm = '0;
  logic       b_sv;
  logic       b_sr = 1'b0;
  logic [7:0] b_sm;
  logic [2:0] b_cnt;
  logic       b_af;
  logic       b_ae;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .WIDTH(8), .DEPTH(DEP), .AF_THRESH(4), .AE_THRESH(1), .PASSTHRU(0)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(a_fl),
    .recv_val(a_rv), .recv_rdy(a_rr), .recv_msg(a_rm),
    .send_val(a_sv), .send_rdy(a_sr), .send_msg(a_sm),
    .count(a_cnt), .almost_full(a_af), .almost_empty(a_ae)
  );

  sync_fifo_flex #(
    .WIDTH(8), .DEPTH(DEP), .PASSTHRU(1)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(b_fl),
    .recv_val(b_rv), .recv_rdy(b_rr), .recv_msg(b_rm),
    .send_val(b_sv), .send_rdy(b_sr), .send_msg(b_sm),
    .count(b_cnt), .almost_full(b_af), .almost_empty(b_ae)
  );

  task automatic drive(input logic v, input logic [7:0] m,
                       input logic r, input logic f);
    a_rv = v;
    a_rm = m;
    a_sr = r;
    a_fl = f;
    #1;
  endtask

  // advance one edge, updating the queue model from the driven inputs
  task automatic tick;
    bit e;
    bit d;
    e = a_rv && !rst && !a_fl && (q.size() < DEP);
    d = a_sr && !rst && !a_fl && (q.size() > 0);
    if (rst || a_fl) begin
      q.delete();
    end else begin
      if (d) void'(q.pop_front());
      if (e) q.push_back(a_rm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    b_rv = 1'b1;
    @(posedge clk);
    #1;
    total += 6;
    if (a_rr !== 1'b0) begin
      bad++; $display("FAIL rst_rdy got=%b want=0", a_rr);
    end
    if (a_sv !== 1'b0) begin
      bad++; $display("FAIL rst_sval got=%b want=0", a_sv);
    end
    if (a_cnt !== 3'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d want=0", a_cnt);
    end
    if (a_ae !== 1'b1) begin
      bad++; $display("FAIL rst_ae got=%b want=1", a_ae);
    end
    if (a_af !== 1'b0) begin
      bad++; $display("FAIL rst_af got=%b want=0", a_af);
    end
    if (b_sv !== 1'b0) begin
      bad++; $display("FAIL rst_byp_sval got=%b want=0", b_sv);
    end
    b_rv = 1'b0;
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    total += 2;
    if (a_rr !== 1'b1) begin
      bad++; $display("FAIL post_rst_rdy got=%b want=1", a_rr);
    end
    if (a_sv !== 1'b0) begin
      bad++; $display("FAIL post_rst_sval got=%b want=0", a_sv);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < DEP; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 0);
      total++;
      if (a_rr !== 1'b1) begin
        bad++; $display("FAIL fill_rdy i=%0d got=%b want=1", i, a_rr);
      end
      tick();
    end
    drive(1, 8'hEE, 0, 0);
    total += 2;
    if (a_rr !== 1'b0) begin
      bad++; $display("FAIL full_rdy got=%b want=0", a_rr);
    end
    if (a_cnt !== 3'd5) begin
      bad++; $display("FAIL full_cnt got=%0d want=5", a_cnt);
    end
    tick();
    for (int i = 0; i < DEP; i++) begin
      drive(0, 8'h00, 1, 0);
      total += 2;
      if (a_sv !== 1'b1) begin
        bad++; $display("FAIL drain_sval i=%0d got=%b want=1", i, a_sv);
      end
      if (a_sm !== 8'hA0 + 8'(i)) begin
        bad++;
        $display("FAIL drain_msg i=%0d got=%h want=%h", i, a_sm, 8'hA0 + 8'(i));
      end
      tick();
    end
    drive(0, 8'h00, 0, 0);
    total += 2;
    if (a_sv !== 1'b0) begin
      bad++; $display("FAIL drained_sval got=%b want=0", a_sv);
    end
    if (a_cnt !== 3'd0) begin
      bad++; $display("FAIL drained_cnt got=%0d want=0", a_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    v = 8'h10;
    for (int i = 0; i < 2; i++) begin
      drive(1, v, 0, 0);
      tick();
      v++;
    end
    for (int i = 0; i < 13; i++) begin
      drive(1, v, 1, 0);
      total += 2;
      if (a_cnt !== 3'd2) begin
        bad++; $display("FAIL wrap_cnt i=%0d got=%0d want=2", i, a_cnt);
      end
      if (a_sm !== q[0]) begin
        bad++; $display("FAIL wrap_msg i=%0d got=%h want=%h", i, a_sm, q[0]);
      end
      tick();
      v++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 8'h00, 1, 0);
      total++;
      if (a_sm !== q[0]) begin
        bad++; $display("FAIL wrap_tail i=%0d got=%h want=%h", i, a_sm, q[0]);
      end
      tick();
    end
  endtask

  task automatic test_full_deq;
    for (int i = 0; i < DEP; i++) begin
      drive(1, 8'h30 + 8'(i), 0, 0);
      tick();
    end
    drive(1, 8'h99, 1, 0);
    total += 2;
    if (a_rr !== 1'b0) begin
      bad++; $display("FAIL fulldeq_rdy got=%b want=0", a_rr);
    end
    if (a_sv !== 1'b1) begin
      bad++; $display("FAIL fulldeq_sval got=%b want=1", a_sv);
    end
    tick();
    drive(0, 8'h00, 0, 0);
    total += 2;
    if (a_cnt !== 3'd4) begin
      bad++; $display("FAIL fulldeq_cnt got=%0d want=4", a_cnt);
    end
    if (a_sm !== 8'h31) begin
      bad++; $display("FAIL fulldeq_head got=%h want=31", a_sm);
    end
    while (q.size() > 0) begin
      drive(0, 8'h00, 1, 0);
      tick();
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h40 + 8'(i), 0, 0);
      tick();
    end
    drive(1, 8'h77, 1, 1);
    total += 2;
    if (a_rr !== 1'b0) begin
      bad++; $display("FAIL flush_rdy got=%b want=0", a_rr);
    end
    if (a_sv !== 1'b0) begin
      bad++; $display("FAIL flush_sval got=%b want=0", a_sv);
    end
    tick();
    drive(0, 8'h00, 0, 0);
    total += 2;
    if (a_cnt !== 3'd0) begin
      bad++; $display("FAIL flush_cnt got=%0d want=0", a_cnt);
    end
    if (a_sv !== 1'b0) begin
      bad++; $display("FAIL flush_after_sval got=%b want=0", a_sv);
    end
    drive(1, 8'h5A, 0, 0);
    tick();
    drive(0, 8'h00, 1, 0);
    total++;
    if (a_sm !== 8'h5A) begin
      bad++; $display("FAIL flush_head got=%h want=5a", a_sm);
    end
    tick();
  endtask

  task automatic test_flags;
    for (int n = 0; n <= DEP; n++) begin
      drive(0, 8'h00, 0, 0);
      total += 3;
      if (a_cnt !== 3'(n)) begin
        bad++; $display("FAIL flag_cnt n=%0d got=%0d", n, a_cnt);
      end
      if (a_ae !== (n <= 1)) begin
        bad++; $display("FAIL flag_ae n=%0d got=%b want=%b", n, a_ae, n <= 1);
      end
      if (a_af !== (n >= 4)) begin
        bad++; $display("FAIL flag_af n=%0d got=%b want=%b", n, a_af, n >= 4);
      end
      if (n < DEP) begin
        drive(1, 8'(n), 0, 0);
        tick();
      end
    end
    while (q.size() > 0) begin
      drive(0, 8'h00, 1, 0);
      tick();
    end
  endtask

  task automatic test_random;
    int ec;
    bit er;
    bit es;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 2) == 0), ($urandom_range(0, 29) == 0));
      ec = rst ? 0 : q.size();
      er = !rst && !a_fl && (q.size() < DEP);
      es = !rst && !a_fl && (q.size() > 0);
      total += 5;
      if (a_cnt !== 3'(ec)) begin
        bad++; $display("FAIL rnd_cnt i=%0d got=%0d want=%0d", i, a_cnt, ec);
      end
      if (a_rr !== er) begin
        bad++; $display("FAIL rnd_rdy i=%0d got=%b want=%b", i, a_rr, er);
      end
      if (a_sv !== es) begin
        bad++; $display("FAIL rnd_sval i=%0d got=%b want=%b", i, a_sv, es);
      end
      if (a_ae !== (ec <= 1)) begin
        bad++; $display("FAIL rnd_ae i=%0d got=%b", i, a_ae);
      end
      if (a_af !== (ec >= 4)) begin
        bad++; $display("FAIL rnd_af i=%0d got=%b", i, a_af);
      end
      if (es) begin
        total++;
        if (a_sm !== q[0]) begin
          bad++; $display("FAIL rnd_msg i=%0d got=%h want=%h", i, a_sm, q[0]);
        end
      end
      tick();
    end
    rst = 1'b0;
    drive(0, 8'h00, 0, 1);
    tick();
    drive(0, 8'h00, 0, 0);
  endtask

  task automatic test_bypass;
    b_rv = 1'b1;
    b_rm = 8'h55;
    b_sr = 1'b1;
    #1;
    total += 3;
    if (b_sv !== 1'b1) begin
      bad++; $display("FAIL byp_sval got=%b want=1", b_sv);
    end
    if (b_sm !== 8'h55) begin
      bad++; $display("FAIL byp_msg got=%h want=55", b_sm);
    end
    if (b_cnt !== 3'd0) begin
      bad++; $display("FAIL byp_cnt0 got=%0d want=0", b_cnt);
    end
    @(posedge clk);
    #1;
    b_rv = 1'b0;
    #1;
    total += 2;
    if (b_cnt !== 3'd0) begin
      bad++; $display("FAIL byp_cnt1 got=%0d want=0", b_cnt);
    end
    if (b_sv !== 1'b0) begin
      bad++; $display("FAIL byp_idle_sval got=%b want=0", b_sv);
    end
    b_rv = 1'b1;
    b_rm = 8'h66;
    b_sr = 1'b0;
    #1;
    total++;
    if (b_sm !== 8'h66) begin
      bad++; $display("FAIL byp_stall_msg got=%h want=66", b_sm);
    end
    @(posedge clk);
    #1;
    b_rv = 1'b0;
    b_rm = 8'h00;
    b_sr = 1'b1;
    #1;
    total += 3;
    if (b_cnt !== 3'd1) begin
      bad++; $display("FAIL byp_held_cnt got=%0d want=1", b_cnt);
    end
    if (b_sv !== 1'b1) begin
      bad++; $display("FAIL byp_held_sval got=%b want=1", b_sv);
    end
    if (b_sm !== 8'h66) begin
      bad++; $display("FAIL byp_held_msg got=%h want=66", b_sm);
    end
    @(posedge clk);
    #1;
    b_sr = 1'b0;
    #1;
    total++;
    if (b_cnt !== 3'd0) begin
      bad++; $display("FAIL byp_end_cnt got=%0d want=0", b_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_deq();
    test_flush();
    test_flags();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
